// File: rtl/alu_pkg.sv
// Shared definitions for blocks that drive the Hack 16-bit ALU.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

    // ALU control codes, packed as {zx, nx, zy, ny, f, no}
    localparam logic [5:0] ALU_ZERO   = 6'b101010;
    localparam logic [5:0] ALU_XPLUSY = 6'b000010;
    localparam logic [5:0] ALU_X      = 6'b001100;
    localparam logic [5:0] ALU_Y      = 6'b110000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DBL  = 2'd2,
        DONE = 2'd3
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add 16-bit multiplier that sequences an external Hack ALU one add/double per cycle.
// Latency: out_valid rises (#ADD + #DBL) + 1 cycles after the request is accepted.
// Backpressure: single request in flight; in_ready only in IDLE; product held until out_ready.
//
// Ports: clk/rst_n (async active-low); request in_valid/in_ready/in_a/in_b;
//        response out_valid/out_ready/out_p/out_zr/out_ng;
//        ALU drive alu_x/alu_y + six control bits, ALU result on alu_out.
// Optional: define ALU_MUL_SEQ_OVF_EN to add out_ovf (unsigned product >= 2^16).
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int N_BITS     = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic        out_zr,
    output logic        out_ng,
`ifdef ALU_MUL_SEQ_OVF_EN
    output logic        out_ovf,
`endif
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out
);

    localparam logic [15:0] B_MASK   = 16'((32'd1 << N_BITS) - 32'd1);
    localparam logic [4:0]  CNT_LAST = 5'(N_BITS - 1);

    mul_state_t  state;
    logic [15:0] acc;
    logic [15:0] a_sh;
    logic [15:0] b_sh;
    logic [4:0]  cnt;

    logic [15:0] b_in_m;
    logic [15:0] b_rest;
    logic [5:0]  alu_ctl;

    assign b_in_m = in_b & B_MASK;
    // Multiplier bits still to be processed after the current doubling
    assign b_rest = {1'b0, b_sh[15:1]};

    assign in_ready = (state == IDLE);

    // ALU drive is a pure decode of the state register, so it never glitches
    // on input changes and alu_out has no path back to the request port.
    always_comb begin
        alu_ctl = ALU_ZERO;
        alu_x   = 16'h0000;
        alu_y   = 16'h0000;
        case (state)
            ADD: begin
                alu_ctl = ALU_XPLUSY;
                alu_x   = acc;
                alu_y   = a_sh;
            end
            DBL: begin
                alu_ctl = ALU_XPLUSY;
                alu_x   = a_sh;
                alu_y   = a_sh;
            end
            default: begin
                alu_ctl = ALU_ZERO;
            end
        endcase
    end

    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = alu_ctl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= 16'h0000;
            a_sh      <= 16'h0000;
            b_sh      <= 16'h0000;
            cnt       <= 5'd0;
            out_valid <= 1'b0;
            out_p     <= 16'h0000;
            out_zr    <= 1'b1;
            out_ng    <= 1'b0;
`ifdef ALU_MUL_SEQ_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc  <= 16'h0000;
                        a_sh <= in_a;
                        b_sh <= b_in_m;
                        cnt  <= 5'd0;
`ifdef ALU_MUL_SEQ_OVF_EN
                        out_ovf <= 1'b0;
`endif
                        if (EARLY_EXIT && (b_in_m == 16'h0000)) begin
                            state <= DONE;
                        end else if (b_in_m[0]) begin
                            state <= ADD;
                        end else begin
                            state <= DBL;
                        end
                    end
                end
                ADD: begin
                    acc <= alu_out;
`ifdef ALU_MUL_SEQ_OVF_EN
                    // Carry out of bit 15, recovered from the operand and sum MSBs
                    if ((acc[15] & a_sh[15]) | ((acc[15] | a_sh[15]) & ~alu_out[15])) begin
                        out_ovf <= 1'b1;
                    end
`endif
                    state <= DBL;
                end
                DBL: begin
                    a_sh <= alu_out;
                    b_sh <= b_rest;
                    cnt  <= cnt + 5'd1;
`ifdef ALU_MUL_SEQ_OVF_EN
                    // A multiplicand bit shifted out still has multiplier bits to meet
                    if (a_sh[15] && (b_rest != 16'h0000)) begin
                        out_ovf <= 1'b1;
                    end
`endif
                    if ((cnt == CNT_LAST) || (EARLY_EXIT && (b_rest == 16'h0000))) begin
                        state <= DONE;
                    end else if (b_sh[1]) begin
                        state <= ADD;
                    end else begin
                        state <= DBL;
                    end
                end
                DONE: begin
                    // First DONE cycle captures the result; afterwards it is held
                    // until the consumer takes it.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_p     <= acc;
                        out_zr    <= (acc == 16'h0000);
                        out_ng    <= acc[15];
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: early-exit and full-length instances
// share stimulus; a Hack ALU model closes the loop for each instance.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;

    // _e: EARLY_EXIT=1 instance, _f: EARLY_EXIT=0 instance
    logic        in_ready_e, out_valid_e, out_zr_e, out_ng_e;
    logic [15:0] out_p_e, alu_x_e, alu_y_e, alu_out_e;
    logic        zx_e, nx_e, zy_e, ny_e, f_e, no_e;
    logic        in_ready_f, out_valid_f, out_zr_f, out_ng_f;
    logic [15:0] out_p_f, alu_x_f, alu_y_f, alu_out_f;
    logic        zx_f, nx_f, zy_f, ny_f, f_f, no_f;
`ifdef ALU_MUL_SEQ_OVF_EN
    logic        out_ovf_e, out_ovf_f;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic zx, input logic nx, input logic zy,
                                             input logic ny, input logic f, input logic no);
        logic [15:0] xx, yy, o;
        xx = zx ? 16'h0000 : x;
        xx = nx ? ~xx : xx;
        yy = zy ? 16'h0000 : y;
        yy = ny ? ~yy : yy;
        o  = f ? (xx + yy) : (xx & yy);
        return no ? ~o : o;
    endfunction

    assign alu_out_e = hack_alu(alu_x_e, alu_y_e, zx_e, nx_e, zy_e, ny_e, f_e, no_e);
    assign alu_out_f = hack_alu(alu_x_f, alu_y_f, zx_f, nx_f, zy_f, ny_f, f_f, no_f);

    alu_mul_seq #(.N_BITS(16), .EARLY_EXIT(1'b1)) dut_e (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_e), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid_e), .out_ready(out_ready), .out_p(out_p_e),
        .out_zr(out_zr_e), .out_ng(out_ng_e),
`ifdef ALU_MUL_SEQ_OVF_EN
        .out_ovf(out_ovf_e),
`endif
        .alu_x(alu_x_e), .alu_y(alu_y_e),
        .alu_zx(zx_e), .alu_nx(nx_e), .alu_zy(zy_e), .alu_ny(ny_e),
        .alu_f(f_e), .alu_no(no_e), .alu_out(alu_out_e)
    );

    alu_mul_seq #(.N_BITS(16), .EARLY_EXIT(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_f), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid_f), .out_ready(out_ready), .out_p(out_p_f),
        .out_zr(out_zr_f), .out_ng(out_ng_f),
`ifdef ALU_MUL_SEQ_OVF_EN
        .out_ovf(out_ovf_f),
`endif
        .alu_x(alu_x_f), .alu_y(alu_y_f),
        .alu_zx(zx_f), .alu_nx(nx_f), .alu_zy(zy_f), .alu_ny(ny_f),
        .alu_f(f_f), .alu_no(no_f), .alu_out(alu_out_f)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference latency: one cycle per add, one per doubling, one to present.
    function automatic int model_lat(input logic [15:0] b, input bit ee);
        int pc  = 0;
        int top = -1;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) begin
                pc++;
                top = i;
            end
        end
        if (!ee) return 16 + pc + 1;
        if (top < 0) return 1;
        return (top + 1) + pc + 1;
    endfunction

    // Caller must be at a negedge with both instances idle.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int hold, input logic [15:0] exp_p,
                          input int exp_le, input int exp_lf, input logic exp_ovf);
        int le = -1;
        int lf = -1;
        logic [15:0] snap_e, snap_f;
        chk({tag, "_idle_rdy"}, {30'd0, in_ready_e, in_ready_f}, 32'd3);
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Requests offered while busy must be ignored
        in_a = ~a;
        in_b = 16'h5A5A;
        for (int k = 1; k <= 60 && (le < 0 || lf < 0); k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid_e && le < 0) le = k;
            if (out_valid_f && lf < 0) lf = k;
            chk({tag, "_busy_rdy"}, {30'd0, in_ready_e, in_ready_f}, 32'd0);
        end
        in_valid = 1'b0;
        chk({tag, "_lat_e"}, le, exp_le);
        chk({tag, "_lat_f"}, lf, exp_lf);
        snap_e = out_p_e;
        snap_f = out_p_f;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_vr"}, {28'd0, out_valid_e, out_valid_f, in_ready_e, in_ready_f}, 32'hC);
            chk({tag, "_hold_p"}, {out_p_e, out_p_f}, {snap_e, snap_f});
        end
        chk({tag, "_p_e"}, out_p_e, exp_p);
        chk({tag, "_p_f"}, out_p_f, exp_p);
        chk({tag, "_zr"}, {30'd0, out_zr_e, out_zr_f}, {30'd0, {2{exp_p == 16'h0000}}});
        chk({tag, "_ng"}, {30'd0, out_ng_e, out_ng_f}, {30'd0, {2{exp_p[15]}}});
`ifdef ALU_MUL_SEQ_OVF_EN
        chk({tag, "_ovf"}, {30'd0, out_ovf_e, out_ovf_f}, {30'd0, {2{exp_ovf}}});
`endif
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post"}, {28'd0, out_valid_e, out_valid_f, in_ready_e, in_ready_f}, 32'h3);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          hold;
        logic [15:0] p;
        int          le;
        int          lf;
        logic        ovf;
    } vec_t;

    vec_t vt[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        logic [31:0] full;

        vt[0] = '{16'h0003, 16'h0005, 0,  16'h000F, 6,  19, 1'b0};
        vt[1] = '{16'h1234, 16'h0000, 0,  16'h0000, 1,  17, 1'b0};
        vt[2] = '{16'hFFFD, 16'h0007, 1,  16'hFFEB, 7,  20, 1'b1};
        vt[3] = '{16'hFFFF, 16'hFFFF, 10, 16'h0001, 33, 33, 1'b1};
        vt[4] = '{16'h0100, 16'h0100, 0,  16'h0000, 11, 18, 1'b1};
        vt[5] = '{16'h0002, 16'h0003, 2,  16'h0006, 5,  19, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = 16'h0000;
        in_b      = 16'h0000;
        repeat (2) @(negedge clk);

        chk("rst_valid", {30'd0, out_valid_e, out_valid_f}, 32'd0);
        chk("rst_rdy", {30'd0, in_ready_e, in_ready_f}, 32'd3);
        chk("rst_p", {out_p_e, out_p_f}, 32'd0);
        chk("rst_zr_ng", {28'd0, out_zr_e, out_zr_f, out_ng_e, out_ng_f}, 32'hC);
        chk("rst_alu_ctl", {26'd0, zx_e, nx_e, zy_e, ny_e, f_e, no_e}, 32'h2A);
        chk("rst_alu_xy", {alu_x_e, alu_y_e}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].hold,
                   vt[i].p, vt[i].le, vt[i].lf, vt[i].ovf);
        end

        // Reset pulse while both instances are doubling
        in_a     = 16'hFFFF;
        in_b     = 16'hFFFF;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_alu_dbl", {alu_x_e, alu_y_e}, {2{16'hFFFF}});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {30'd0, out_valid_e, out_valid_f}, 32'd0);
        chk("mid_rst_rdy", {30'd0, in_ready_e, in_ready_f}, 32'd3);
        chk("mid_rst_p_zr", {out_p_e, 14'd0, out_zr_e, out_zr_f}, 32'd3);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_rst", 16'h0007, 16'h0006, 0, 16'h002A, 6, 19, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'($urandom);
                1:       rb = 16'($urandom_range(0, 15));
                2:       rb = 16'h0001 << $urandom_range(0, 15);
                default: rb = 16'($urandom) & 16'h00FF;
            endcase
            full = {16'd0, ra} * {16'd0, rb};
            run_op($sformatf("rnd%0d", i), ra, rb, $urandom_range(0, 2), full[15:0],
                   model_lat(rb, 1'b1), model_lat(rb, 1'b0), full >= 32'h0001_0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
